// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder built from 1-bit full-adder cells, with carry
// chaining across beats so operands wider than WIDTH can be summed piecewise.
module full_adder_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             chain_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  logic [WIDTH:0]   carry_p0;
  logic [WIDTH-1:0] sum_p0;
  logic             ovf_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] sum_p1;
  logic             cout_p1;
  logic             ovf_p1;

  // Stage p0: combinational carry chain from the input pins
  always_comb begin
    carry_p0    = '0;
    sum_p0      = '0;
    carry_p0[0] = chain_en ? cout_p1 : cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum_p0[i]     = fa_sum(a[i], b[i], carry_p0[i]);
      carry_p0[i+1] = fa_carry(a[i], b[i], carry_p0[i]);
    end
    ovf_p0 = carry_p0[WIDTH] ^ carry_p0[WIDTH-1];
  end

  // Stage p1: result registers; they hold across idle cycles so cout_p1
  // survives a gap and can seed a later chained beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sum_p1  <= sum_p0;
        cout_p1 <= carry_p0[WIDTH];
        ovf_p1  <= ovf_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign sum       = sum_p1;
  assign cout      = cout_p1;
  assign ovf       = ovf_p1;

endmodule

// File: tb/tb_full_adder_reg.sv
// Bench for full_adder_reg: three instances (WIDTH 1, 8, 16) checked every cycle
// against an arithmetic reference model, plus hand-computed literal expectations.
module tb_full_adder_reg;

  logic        clk;
  logic        rst_n;
  logic [2:0]  vld;
  logic [2:0]  cin;
  logic [2:0]  ch;
  logic [0:0]  a1, b1;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic [2:0]  ov, co, of;
  logic [0:0]  s1;
  logic [7:0]  s8;
  logic [15:0] s16;

  int n_vec = 0;
  int n_bad = 0;

  full_adder_reg #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .a(a1), .b(b1), .cin(cin[0]),
    .chain_en(ch[0]), .out_valid(ov[0]), .sum(s1), .cout(co[0]), .ovf(of[0]));
  full_adder_reg #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .a(a8), .b(b8), .cin(cin[1]),
    .chain_en(ch[1]), .out_valid(ov[1]), .sum(s8), .cout(co[1]), .ovf(of[1]));
  full_adder_reg #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .a(a16), .b(b16), .cin(cin[2]),
    .chain_en(ch[2]), .out_valid(ov[2]), .sum(s16), .cout(co[2]), .ovf(of[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wid(input int k);
    return (k == 0) ? 1 : (k == 1) ? 8 : 16;
  endfunction

  function automatic logic [63:0] get_a(input int k);
    return (k == 0) ? 64'(a1) : (k == 1) ? 64'(a8) : 64'(a16);
  endfunction

  function automatic logic [63:0] get_b(input int k);
    return (k == 0) ? 64'(b1) : (k == 1) ? 64'(b8) : 64'(b16);
  endfunction

  function automatic logic [63:0] get_s(input int k);
    return (k == 0) ? 64'(s1) : (k == 1) ? 64'(s8) : 64'(s16);
  endfunction

  // Reference model: plain integer arithmetic on unsigned and signed views
  function automatic logic [64:0] full_add(input int k, input logic ce);
    return {1'b0, get_a(k)} + {1'b0, get_b(k)} + 65'(ce);
  endfunction

  function automatic logic [63:0] mdl_sum(input int k, input logic ce);
    logic [64:0] f;
    f = full_add(k, ce);
    return f[63:0] & ((64'd1 << wid(k)) - 64'd1);
  endfunction

  function automatic logic mdl_cout(input int k, input logic ce);
    logic [64:0] f;
    f = full_add(k, ce);
    return f[wid(k)];
  endfunction

  function automatic longint sx(input logic [63:0] v, input int w);
    if (v[w-1]) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  function automatic logic mdl_ovf(input int k, input logic ce);
    longint r, lim;
    int w;
    w   = wid(k);
    lim = longint'(1) << (w - 1);
    r   = sx(get_a(k), w) + sx(get_b(k), w) + longint'(ce);
    return (r > lim - 1) || (r < -lim);
  endfunction

  logic [63:0] m_sum [3];
  logic        m_cout[3];
  logic        m_ovf [3];
  logic        m_vld [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_sum[k] <= '0; m_cout[k] <= 1'b0; m_ovf[k] <= 1'b0; m_vld[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_vld[k] <= vld[k];
        if (vld[k]) begin
          m_sum[k]  <= mdl_sum(k, ch[k] ? m_cout[k] : cin[k]);
          m_cout[k] <= mdl_cout(k, ch[k] ? m_cout[k] : cin[k]);
          m_ovf[k]  <= mdl_ovf(k, ch[k] ? m_cout[k] : cin[k]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, required %h", nm, $time, got, want);
    end
  endtask

  // Model comparison on every cycle, away from the active edge
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mdl_out_valid[w%0d]", wid(k)), 64'(ov[k]), 64'(m_vld[k]));
      chk($sformatf("mdl_sum[w%0d]", wid(k)), get_s(k), m_sum[k]);
      chk($sformatf("mdl_cout[w%0d]", wid(k)), 64'(co[k]), 64'(m_cout[k]));
      chk($sformatf("mdl_ovf[w%0d]", wid(k)), 64'(of[k]), 64'(m_ovf[k]));
    end
  end

  task automatic lit(input string nm, input int k, input logic [63:0] es,
                     input logic ec, input logic eo, input logic ev);
    chk({nm, ".sum"}, get_s(k), es);
    chk({nm, ".cout"}, 64'(co[k]), 64'(ec));
    chk({nm, ".ovf"}, 64'(of[k]), 64'(eo));
    chk({nm, ".out_valid"}, 64'(ov[k]), 64'(ev));
  endtask

  task automatic apply(input int k, input logic [63:0] av, input logic [63:0] bv,
                       input logic c, input logic chn);
    case (k)
      0: begin a1 = av[0:0]; b1 = bv[0:0]; end
      1: begin a8 = av[7:0]; b8 = bv[7:0]; end
      default: begin a16 = av[15:0]; b16 = bv[15:0]; end
    endcase
    vld    = 3'b000;
    vld[k] = 1'b1;
    cin[k] = c;
    ch[k]  = chn;
    @(negedge clk);
  endtask

  task automatic idle();
    vld = 3'b000;
    @(negedge clk);
  endtask

  logic [7:0] tt_s, tt_c, tt_o;

  initial begin
    rst_n = 1'b0;
    vld = '0; cin = '0; ch = '0;
    a1 = '0; b1 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    tt_s = 8'b1001_0110;
    tt_c = 8'b1110_1000;
    tt_o = 8'b0100_0010;

    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) lit("reset_state", k, 0, 0, 0, 0);
    rst_n = 1'b1;

    // 1-bit truth table, back to back
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      apply(0, 64'(v[2]), 64'(v[1]), v[0], 1'b0);
      lit($sformatf("truth_%0d", i), 0, 64'(tt_s[i]), tt_c[i], tt_o[i], 1'b1);
    end

    // 8-bit boundaries
    apply(1, 64'hFF, 64'h01, 1'b0, 1'b0);
    lit("w8_ff_plus_1", 1, 64'h00, 1'b1, 1'b0, 1'b1);
    apply(1, 64'h7F, 64'h01, 1'b0, 1'b0);
    lit("w8_7f_plus_1", 1, 64'h80, 1'b0, 1'b1, 1'b1);

    // 0x01FF + 0x0001 over two chained beats
    apply(1, 64'hFF, 64'h01, 1'b0, 1'b0);
    lit("chain_lo", 1, 64'h00, 1'b1, 1'b0, 1'b1);
    apply(1, 64'h01, 64'h00, 1'b0, 1'b1);
    lit("chain_hi", 1, 64'h02, 1'b0, 1'b0, 1'b1);

    // Valid gap: outputs hold, chained beat uses pre-gap carry
    apply(1, 64'hF0, 64'h20, 1'b0, 1'b0);
    lit("gap_beat", 1, 64'h10, 1'b1, 1'b0, 1'b1);
    for (int g = 0; g < 3; g++) begin
      idle();
      lit($sformatf("gap_hold_%0d", g), 1, 64'h10, 1'b1, 1'b0, 1'b0);
    end
    apply(1, 64'h05, 64'h00, 1'b0, 1'b1);
    lit("gap_chain", 1, 64'h06, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle, then confirm the chain carry is cleared
    a1 = 1'b1; b1 = 1'b1; cin[0] = 1'b1; ch[0] = 1'b0;
    a8 = 8'hFF; b8 = 8'h01; cin[1] = 1'b0; ch[1] = 1'b0;
    vld = 3'b011;
    @(posedge clk);
    #2;
    lit("pre_reset_w1", 0, 64'h1, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    lit("async_reset_w1", 0, 0, 0, 0, 0);
    lit("async_reset_w8", 1, 0, 0, 0, 0);
    @(negedge clk);
    vld = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 64'h01, 64'h00, 1'b0, 1'b1);
    lit("chain_after_reset", 1, 64'h01, 1'b0, 1'b0, 1'b1);

    // 16-bit pins, then random regression
    apply(2, 64'hFFFF, 64'hFFFF, 1'b1, 1'b0);
    lit("w16_ffff_ffff_c1", 2, 64'hFFFF, 1'b1, 1'b0, 1'b1);
    apply(2, 64'h8000, 64'h8000, 1'b0, 1'b0);
    lit("w16_8000_8000", 2, 64'h0000, 1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 1000; n++) begin
      apply(2, 64'($urandom_range(0, 65535)), 64'($urandom_range(0, 65535)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 15) == 0) idle();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
